// File: rtl/bip_control.sv
// bip_control: BIP fetch/execute control unit driving accumulator, ALU, data RAM strobes and PC
//
// Ports:
//   clk          single clock, all state on posedge
//   reset        synchronous active-high reset; also masks all strobes combinationally
//   start        begin execution from IDLE
//   instruction  program ROM data, valid one cycle after pcOut is presented
//   pcOut        registered program ROM address
//   operandExt   instruction[10:0] sign-extended to DATA_LENGTH
//   dataAddr     data RAM address = instruction[10:0]
//   selA         accumulator input select (0 RAM, 1 operandExt, 2 ALU)
//   selB         ALU operand B select (0 RAM, 1 operandExt)
//   op           ALU op (0 add, 1 sub)
//   wrAcc        accumulator enable
//   wrRam        data RAM write strobe
//   rdRam        data RAM read strobe
//   cycleCount   saturating FETCH/EXEC cycle counter (only with BIP_CYCLE_COUNT_EN)
//   halted       high in HALT
//
// Optional feature macro: BIP_CYCLE_COUNT_EN
module bip_control #(
    parameter int PC_LENGTH     = 11,
    parameter int DATA_LENGTH   = 16,
    parameter int OPCODE_LENGTH = 5,
    parameter int COUNT_LENGTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DATA_LENGTH-1:0] instruction,
    output logic [PC_LENGTH-1:0]   pcOut,
    output logic [DATA_LENGTH-1:0] operandExt,
    output logic [PC_LENGTH-1:0]   dataAddr,
    output logic [1:0]             selA,
    output logic                   selB,
    output logic                   op,
    output logic                   wrAcc,
    output logic                   wrRam,
    output logic                   rdRam,
`ifdef BIP_CYCLE_COUNT_EN
    output logic [COUNT_LENGTH-1:0] cycleCount,
`endif
    output logic                   halted
);
    localparam int OPND_LENGTH = DATA_LENGTH - OPCODE_LENGTH;
    localparam logic [OPCODE_LENGTH-1:0] OP_HLT  = OPCODE_LENGTH'(0);
    localparam logic [OPCODE_LENGTH-1:0] OP_STO  = OPCODE_LENGTH'(1);
    localparam logic [OPCODE_LENGTH-1:0] OP_LD   = OPCODE_LENGTH'(2);
    localparam logic [OPCODE_LENGTH-1:0] OP_LDI  = OPCODE_LENGTH'(3);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADDI = OPCODE_LENGTH'(5);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(6);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUBI = OPCODE_LENGTH'(7);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t                   state_q;
    logic [PC_LENGTH-1:0]     pc_q;
    logic [PC_LENGTH-1:0]     pc_d;
    logic                     halted_q;
    logic [OPCODE_LENGTH-1:0] opcode;

    assign opcode     = instruction[DATA_LENGTH-1 -: OPCODE_LENGTH];
    assign operandExt = {{OPCODE_LENGTH{instruction[OPND_LENGTH-1]}}, instruction[OPND_LENGTH-1:0]};
    assign dataAddr   = instruction[PC_LENGTH-1:0];
    assign pc_d       = pc_q + PC_LENGTH'(1);
    assign pcOut      = pc_q;
    assign halted     = halted_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE:  state_q <= start ? FETCH : IDLE;
                FETCH: state_q <= EXEC;
                EXEC: begin
                    if (opcode == OP_HLT) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= FETCH;
                        pc_q    <= pc_d;
                    end
                end
                default: state_q <= HALT;
            endcase
        end
    end

    // Strobes are decoded straight from the ROM word so the accumulator and RAM act on the closing edge of EXEC.
    always_comb begin
        wrAcc = 1'b0;
        wrRam = 1'b0;
        rdRam = 1'b0;
        selA  = 2'd0;
        selB  = 1'b0;
        op    = 1'b0;
        if (state_q == EXEC && !reset) begin
            case (opcode)
                OP_STO: wrRam = 1'b1;
                OP_LD: begin
                    rdRam = 1'b1;
                    wrAcc = 1'b1;
                end
                OP_LDI: begin
                    selA  = 2'd1;
                    wrAcc = 1'b1;
                end
                OP_ADD: begin
                    rdRam = 1'b1;
                    selA  = 2'd2;
                    wrAcc = 1'b1;
                end
                OP_ADDI: begin
                    selA  = 2'd2;
                    selB  = 1'b1;
                    wrAcc = 1'b1;
                end
                OP_SUB: begin
                    rdRam = 1'b1;
                    selA  = 2'd2;
                    op    = 1'b1;
                    wrAcc = 1'b1;
                end
                OP_SUBI: begin
                    selA  = 2'd2;
                    selB  = 1'b1;
                    op    = 1'b1;
                    wrAcc = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BIP_CYCLE_COUNT_EN
    logic [COUNT_LENGTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if ((state_q == FETCH || state_q == EXEC) && !(&cnt_q))
            cnt_q <= cnt_q + COUNT_LENGTH'(1);
    end

    assign cycleCount = cnt_q;
`endif
endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: randomized self-checking bench for bip_control against an instruction-level model
module tb_bip_control;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] instruction = '0;
    logic [10:0] pcOut;
    logic [15:0] operandExt;
    logic [10:0] dataAddr;
    logic [1:0]  selA;
    logic        selB, op, wrAcc, wrRam, rdRam, halted;
`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] cycleCount;
`endif

    logic [15:0] rom [0:2047];
    int checks = 0;
    int errors = 0;
    int exp_pc;
    bit exp_halt;

    bip_control dut (
        .clk(clk), .reset(reset), .start(start), .instruction(instruction),
        .pcOut(pcOut), .operandExt(operandExt), .dataAddr(dataAddr),
        .selA(selA), .selB(selB), .op(op), .wrAcc(wrAcc), .wrRam(wrRam), .rdRam(rdRam),
`ifdef BIP_CYCLE_COUNT_EN
        .cycleCount(cycleCount),
`endif
        .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) instruction <= rom[pcOut];

    wire [6:0] ctl = {wrAcc, wrRam, rdRam, selA, selB, op};

    // Instruction semantics: which unit the opcode touches and how.
    function automatic logic [6:0] exp_ctl(input int opc);
        bit reads = (opc == 2 || opc == 4 || opc == 6);
        bit imm_alu = (opc == 5 || opc == 7);
        bit alu = (opc >= 4 && opc <= 7);
        bit writes_acc = (opc >= 2 && opc <= 7);
        logic [1:0] sa = alu ? 2'd2 : (opc == 3 ? 2'd1 : 2'd0);
        return {writes_acc, opc == 1, reads, sa, imm_alu, opc == 6 || opc == 7};
    endfunction

    function automatic logic [15:0] exp_ext(input logic [15:0] ins);
        int v = int'(ins[10:0]);
        if (v >= 1024) v -= 2048;
        return 16'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 2048; i++) rom[i] = 16'hF800;
    endtask

    task automatic do_start();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_pc = 0;
        exp_halt = 1'b0;
    endtask

    // Steps up to n instructions from FETCH, checking every FETCH and EXEC cycle against the model.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] ins = rom[exp_pc];
            int opc = int'(ins[15:11]);
            checks++;
            if (pcOut !== 11'(exp_pc) || ctl !== 7'd0 || halted !== 1'b0) begin
                errors++;
                $display("FAIL fetch[%0d]: pc=%0d ctl=%b halted=%b, expected pc=%0d ctl=0 halted=0", i, pcOut, ctl, halted, exp_pc);
            end
            tick();
            checks++;
            if (ctl !== exp_ctl(opc) || operandExt !== exp_ext(ins) || dataAddr !== ins[10:0] || pcOut !== 11'(exp_pc)) begin
                errors++;
                $display("FAIL exec[%0d] ins=%h: ctl=%b ext=%h addr=%0d pc=%0d, expected ctl=%b ext=%h addr=%0d pc=%0d",
                         i, ins, ctl, operandExt, dataAddr, pcOut, exp_ctl(opc), exp_ext(ins), ins[10:0], exp_pc);
            end
            if (opc == 0) exp_halt = 1'b1;
            else exp_pc = (exp_pc + 1) % 2048;
            tick();
            if (exp_halt) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if (pcOut !== 11'd0 || halted !== 1'b0 || ctl !== 7'd0) begin
            errors++;
            $display("FAIL reset_values: pc=%0d halted=%b ctl=%b, expected 0 0 0", pcOut, halted, ctl);
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (pcOut !== 11'd0 || ctl !== 7'd0) begin
            errors++;
            $display("FAIL idle_no_start: pc=%0d ctl=%b, expected 0 0", pcOut, ctl);
        end
    endtask

    task automatic test_ldi();
        clear_rom();
        rom[0] = 16'h1805;
        do_start();
        tick();
        checks++;
        if (wrAcc !== 1'b1 || selA !== 2'd1 || operandExt !== 16'h0005) begin
            errors++;
            $display("FAIL ldi5: wrAcc=%b selA=%0d ext=%h, expected 1 1 0005", wrAcc, selA, operandExt);
        end
        tick();
        checks++;
        if (pcOut !== 11'd1 || ctl !== 7'd0) begin
            errors++;
            $display("FAIL ldi5_pc: pc=%0d ctl=%b, expected 1 0", pcOut, ctl);
        end
    endtask

    task automatic test_imm_seq();
        clear_rom();
        rom[0] = 16'h1FFF;
        rom[1] = 16'h2801;
        rom[2] = 16'h3803;
        do_start();
        tick();
        checks++;
        if (operandExt !== 16'hFFFF || selA !== 2'd1) begin
            errors++;
            $display("FAIL ldi_7ff: ext=%h selA=%0d, expected ffff 1", operandExt, selA);
        end
        tick();
        exp_pc = 1;
        run(2);
    endtask

    task automatic test_mem_hlt();
        clear_rom();
        rom[0] = 16'h1004;
        rom[1] = 16'h2004;
        rom[2] = 16'h0806;
        rom[3] = 16'h0000;
        do_start();
        run(4);
        checks++;
        if (halted !== 1'b1 || ctl !== 7'd0 || pcOut !== 11'd3) begin
            errors++;
            $display("FAIL halt_after_8: halted=%b ctl=%b pc=%0d, expected 1 0 3", halted, ctl, pcOut);
        end
`ifdef BIP_CYCLE_COUNT_EN
        checks++;
        if (cycleCount !== 32'd8) begin
            errors++;
            $display("FAIL count_8: got %0d, expected 8", cycleCount);
        end
`endif
        start = 1'b1;
        repeat (4) tick();
        start = 1'b0;
        checks++;
        if (halted !== 1'b1 || ctl !== 7'd0 || pcOut !== 11'd3) begin
            errors++;
            $display("FAIL halt_ignores_start: halted=%b ctl=%b pc=%0d, expected 1 0 3", halted, ctl, pcOut);
        end
`ifdef BIP_CYCLE_COUNT_EN
        checks++;
        if (cycleCount !== 32'd8) begin
            errors++;
            $display("FAIL count_frozen: got %0d, expected 8", cycleCount);
        end
`endif
    endtask

    task automatic test_nop_wrap();
        clear_rom();
        for (int i = 0; i < 2048; i++) rom[i] = {5'(8 + $urandom_range(0, 23)), 11'($urandom)};
        do_start();
        run(2049);
        checks++;
        if (exp_pc !== 1 || pcOut !== 11'd1) begin
            errors++;
            $display("FAIL pc_wrap: pc=%0d, expected 1", pcOut);
        end
    endtask

    task automatic test_reset_mid_exec();
        clear_rom();
        rom[0] = 16'h1805;
        do_start();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== 7'd0) begin
            errors++;
            $display("FAIL reset_masks_strobes: ctl=%b, expected 0", ctl);
        end
        tick();
        reset = 1'b0;
        checks++;
        if (pcOut !== 11'd0 || halted !== 1'b0 || ctl !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_exec: pc=%0d halted=%b ctl=%b, expected 0 0 0", pcOut, halted, ctl);
        end
        repeat (3) tick();
        checks++;
        if (pcOut !== 11'd0 || ctl !== 7'd0) begin
            errors++;
            $display("FAIL reset_to_idle: pc=%0d ctl=%b, expected 0 0", pcOut, ctl);
        end
`ifdef BIP_CYCLE_COUNT_EN
        checks++;
        if (cycleCount !== 32'd0) begin
            errors++;
            $display("FAIL count_reset: got %0d, expected 0", cycleCount);
        end
`endif
    endtask

    task automatic test_random();
        clear_rom();
        for (int i = 0; i < 60; i++) rom[i] = {5'($urandom_range(1, 31)), 11'($urandom)};
        rom[60] = {5'd0, 11'($urandom)};
        do_start();
        start = 1'b1;
        run(61);
        checks++;
        if (halted !== 1'b1 || pcOut !== 11'd60 || !exp_halt) begin
            errors++;
            $display("FAIL random_halt: halted=%b pc=%0d, expected 1 60", halted, pcOut);
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_imm_seq();
        test_mem_hlt();
        test_reset_mid_exec();
        test_random();
        test_nop_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Control unit for the BIP datapath. Sits directly upstream of the accumulator and drives its write enable (`wrAcc`).
- Drives the accumulator input mux, the ALU operand select and op, the data RAM strobes, and the program counter.
- Sequences a multi-cycle fetch/execute loop against a synchronous-read program ROM until it decodes HLT.

Parameters:
- PC_LENGTH, 11, program counter and ROM address width
- DATA_LENGTH, 16, instruction and datapath width
- OPCODE_LENGTH, 5, opcode field width (instruction[15:11])
- COUNT_LENGTH, 32, cycle counter width (used only with the optional feature)

Ports:
- clk  input  1  single clock; all state updates on the posedge
- reset  input  1  synchronous, active-high; clears all state on the posedge where it is high
- start  input  1  begin execution from IDLE
- instruction  input  DATA_LENGTH  program ROM data; valid one cycle after pcOut is presented
- pcOut  output  PC_LENGTH  program ROM address (registered)
- operandExt  output  DATA_LENGTH  instruction[10:0] sign-extended on bit 10
- dataAddr  output  PC_LENGTH  data RAM address = instruction[10:0]
- selA  output  2  accumulator input select: 0 = data RAM, 1 = operandExt, 2 = ALU result
- selB  output  1  ALU operand B: 0 = data RAM, 1 = operandExt
- op  output  1  ALU op: 0 = add, 1 = sub
- wrAcc  output  1  accumulator enable
- wrRam  output  1  data RAM write strobe
- rdRam  output  1  data RAM read strobe; the RAM reads combinationally
- halted  output  1  high in HALT

Behaviour:
- States: IDLE, FETCH, EXEC, HALT.
- Reset values: state = IDLE, pcOut = 0, halted = 0.
- While reset is high, wrAcc, wrRam, rdRam, selA, selB and op are forced to 0 combinationally.
- IDLE:
  - start = 1 moves to FETCH on the next edge.
  - Outputs are otherwise inactive.
- FETCH:
  - pcOut is held; the ROM returns the instruction by the next edge.
  - Always moves to EXEC.
- EXEC:
  - Decoding is combinational from instruction and state = EXEC.
  - Strobes are high for exactly this one cycle, so the accumulator captures on the closing edge of EXEC.
  - Decode per opcode:
    - 00000 HLT: no strobes; next state HALT; pcOut unchanged.
    - 00001 STO: wrRam = 1.
    - 00010 LD: rdRam = 1, selA = 0, wrAcc = 1.
    - 00011 LDI: selA = 1, wrAcc = 1.
    - 00100 ADD: rdRam = 1, selA = 2, selB = 0, op = 0, wrAcc = 1.
    - 00101 ADDI: selA = 2, selB = 1, op = 0, wrAcc = 1.
    - 00110 SUB: rdRam = 1, selA = 2, selB = 0, op = 1, wrAcc = 1.
    - 00111 SUBI: selA = 2, selB = 1, op = 1, wrAcc = 1.
    - 01000..11111: NOP; no strobes; PC advances.
  - Every opcode except HLT returns to FETCH with pcOut + 1.
  - Throughput: 2 cycles per instruction.
- HALT:
  - halted = 1 and all strobes are 0.
  - start is ignored; only reset leaves HALT.
- PC wrap: pcOut = 2^PC_LENGTH-1 advances to 0; no flag is raised.
- Reset mid-EXEC:
  - No strobe is seen during the reset cycle.
  - The next cycle is IDLE with pcOut = 0.
- start held high continuously: no effect outside IDLE.
- Outside EXEC, selA, selB and op are 0.

Optional Feature:
- Macro: BIP_CYCLE_COUNT_EN.
- When defined:
  - Adds output cycleCount (COUNT_LENGTH bits), reset to 0.
  - Increments on every edge where state is FETCH or EXEC.
  - Freezes in HALT and IDLE.
  - Saturates at all-ones.
- When undefined: the port and the counter logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, start = 1 for 1 cycle, ROM[0] = LDI 5 (0x1805) -> wrAcc = 1 and selA = 1 in cycle 3; operandExt = 0x0005; pcOut = 1 after.
- ROM: LDI 0x7FF, ADDI 1, SUBI 3 -> EXEC strobes: (selA = 1), (selA = 2, selB = 1, op = 0), (selA = 2, selB = 1, op = 1); operandExt for LDI 0x7FF = 0xFFFF.
- ROM: LD 4, ADD 4, STO 6, HLT -> rdRam with dataAddr = 4 on LD and ADD; wrRam with dataAddr = 6 on STO; halted = 1 after 8 cycles; start ignored thereafter.
- Opcode 0x1F in ROM -> no strobes, pcOut increments; PC forced to 2047 executing NOP -> pcOut = 0 next.
- reset asserted during EXEC of LDI -> wrAcc = 0 that cycle, state IDLE, pcOut = 0; with BIP_CYCLE_COUNT_EN, a 4-instruction program ending in HLT -> cycleCount = 8, frozen.
